// File: rtl/upsampling_layer_pkg.sv
// Shared definitions for the nearest-neighbour upsampler: state encodings and counter sizing.
package upsampling_layer_pkg;

  localparam logic [0:0] ST_LOAD   = 1'b0;
  localparam logic [0:0] ST_REPLAY = 1'b1;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/upsample_row_buffer.sv
// One input row of packed multi-channel pixels; written while loading, read back while replaying.
module upsample_row_buffer #(
  parameter int unsigned DEPTH = 14,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             clk_en,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; every slot is rewritten before it is replayed.
  always_ff @(posedge clk) begin
    if (clk_en && wr_en) mem[addr] <= wr_data;
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/upsampling_layer.sv
// Nearest-neighbour upsampler: repeats each pixel SCALE times per row and each row SCALE times.
module upsampling_layer
  import upsampling_layer_pkg::*;
#(
  parameter int unsigned D_WIDTH    = 16,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned IMAGE_SIZE = 14,
  parameter int unsigned SCALE      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic [D_WIDTH*CHANNELS-1:0] input_data,
  input  logic                        input_valid,
  output logic                        input_ready,
  output logic [D_WIDTH*CHANNELS-1:0] output_data,
  output logic                        valid
);

  localparam int unsigned DW     = D_WIDTH * CHANNELS;
  localparam int unsigned COL_W  = cnt_w(IMAGE_SIZE - 1);
  localparam int unsigned REP_W  = cnt_w(SCALE);
  localparam int unsigned RREP_W = cnt_w(SCALE - 1);
  localparam int unsigned ROW_W  = cnt_w(IMAGE_SIZE - 1);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMAGE_SIZE - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(SCALE);
  localparam logic [RREP_W-1:0] RREP_LAST = RREP_W'((SCALE > 1) ? SCALE - 2 : 0);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMAGE_SIZE - 1);
  localparam bit                MULTI     = (SCALE > 1);

  logic [0:0]        state,       state_nxt;
  logic [COL_W-1:0]  col,         col_nxt;
  logic [REP_W-1:0]  rep,         rep_nxt;
  logic [RREP_W-1:0] row_rep,     row_rep_nxt;
  logic [ROW_W-1:0]  row,         row_nxt;
  logic              valid_nxt;
  logic [DW-1:0]     data_nxt;

  logic              last_copy;
  logic              xfer;
  logic [COL_W-1:0]  col_inc;
  logic [ROW_W-1:0]  row_inc;
  logic [COL_W-1:0]  buf_addr;
  logic [DW-1:0]     buf_rd;

  assign last_copy = (rep == REP_LAST);
  assign col_inc   = (col == COL_LAST) ? '0 : col + COL_W'(1);
  assign row_inc   = (row == ROW_LAST) ? '0 : row + ROW_W'(1);

  // Once the current pixel's last copy is out, both the next write and the next replay read target col+1.
  assign buf_addr  = last_copy ? col_inc : col;

  assign input_ready = (state == ST_LOAD) && (!valid || last_copy)
                     && !(MULTI && last_copy && (col == COL_LAST));
  assign xfer        = clk_en && input_valid && input_ready;

  upsample_row_buffer #(
    .DEPTH (IMAGE_SIZE),
    .WIDTH (DW),
    .AW    (COL_W)
  ) u_row_buffer (
    .clk     (clk),
    .clk_en  (clk_en),
    .wr_en   (xfer),
    .addr    (buf_addr),
    .wr_data (input_data),
    .rd_data (buf_rd)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    rep_nxt     = rep;
    row_rep_nxt = row_rep;
    row_nxt     = row;
    valid_nxt   = valid;
    data_nxt    = output_data;
    if (clk_en) begin
      if (state == ST_LOAD) begin
        if (last_copy) begin
          col_nxt   = col_inc;
          valid_nxt = 1'b0;
          rep_nxt   = '0;
          if (col == COL_LAST) begin
            if (MULTI) begin
              state_nxt   = ST_REPLAY;
              valid_nxt   = 1'b1;
              rep_nxt     = REP_W'(1);
              data_nxt    = buf_rd;
              row_rep_nxt = '0;
            end else begin
              row_nxt = row_inc;
            end
          end
        end else if (valid) begin
          rep_nxt = rep + REP_W'(1);
        end
        if (xfer) begin
          data_nxt  = input_data;
          valid_nxt = 1'b1;
          rep_nxt   = REP_W'(1);
        end
      end else begin
        valid_nxt = 1'b1;
        data_nxt  = buf_rd;
        if (last_copy) begin
          rep_nxt = REP_W'(1);
          col_nxt = col_inc;
          if (col == COL_LAST) begin
            if (row_rep == RREP_LAST) begin
              state_nxt   = ST_LOAD;
              valid_nxt   = 1'b0;
              rep_nxt     = '0;
              row_rep_nxt = '0;
              row_nxt     = row_inc;
              data_nxt    = output_data;
            end else begin
              row_rep_nxt = row_rep + RREP_W'(1);
            end
          end
        end else begin
          rep_nxt = rep + REP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      col         <= '0;
      rep         <= '0;
      row_rep     <= '0;
      row         <= '0;
      valid       <= 1'b0;
      output_data <= '0;
    end else begin
      state       <= state_nxt;
      col         <= col_nxt;
      rep         <= rep_nxt;
      row_rep     <= row_rep_nxt;
      row         <= row_nxt;
      valid       <= valid_nxt;
      output_data <= data_nxt;
    end
  end

endmodule

// File: tb/tb_upsampling_layer.sv
// Bench for upsampling_layer: directed scenarios on a 2x2/x2 instance, random scoreboards on both instances.
module tb_upsampling_layer;

  localparam int unsigned IS_A = 2;
  localparam int unsigned S_A  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_a, v_a, rdy_a, ov_a;
  logic [7:0]  d_a, od_a;
  logic        en_b, v_b, rdy_b, ov_b;
  logic [15:0] d_b, od_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] src_a[$];
  logic [7:0] got_a[$];
  logic       rdy_q[$];
  int         first_acc, first_out;

  upsampling_layer #(.D_WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(IS_A), .SCALE(S_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_en(en_a), .input_data(d_a), .input_valid(v_a),
    .input_ready(rdy_a), .output_data(od_a), .valid(ov_a));

  upsampling_layer #(.D_WIDTH(8), .CHANNELS(2), .IMAGE_SIZE(3), .SCALE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_en(en_b), .input_data(d_b), .input_valid(v_b),
    .input_ready(rdy_b), .output_data(od_b), .valid(ov_b));

  // One clock on instance A; returns whether the bench's offer was taken at that edge.
  task automatic step_a(input logic en, input logic v, input logic [7:0] d, output logic acc);
    en_a = en; v_a = v; d_a = d;
    #1 acc = en && v && rdy_a;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic en, input logic v, input logic [15:0] d, output logic acc);
    en_b = en; v_b = v; d_b = d;
    #1 acc = en && v && rdy_b;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    en_a = 1'b0; v_a = 1'b0; d_a = '0;
    en_b = 1'b0; v_b = 1'b0; d_b = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Feed src_a with valid held whenever data is queued, collecting valid outputs.
  task automatic feed_a(input int n_out);
    logic acc;
    int   cyc;
    cyc = 0;
    got_a.delete(); rdy_q.delete();
    first_acc = -1; first_out = -1;
    while (got_a.size() < n_out && cyc < 80) begin
      step_a(1'b1, src_a.size() > 0, (src_a.size() > 0) ? src_a[0] : 8'h00, acc);
      if (acc) begin
        void'(src_a.pop_front());
        if (first_acc < 0) first_acc = cyc;
      end
      if (ov_a) begin
        got_a.push_back(od_a);
        rdy_q.push_back(rdy_a);
        if (first_out < 0) first_out = cyc;
      end
      cyc++;
    end
  endtask

  task automatic test_reset();
    en_a = 1'b0; v_a = 1'b0; d_a = '0;
    en_b = 1'b0; v_b = 1'b0; d_b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a got %0b want 0", ov_a); end
    checks++; if (od_a !== 8'h00) begin errors++; $display("FAIL reset_data_a got %h want 00", od_a); end
    checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %0b want 0", ov_b); end
    rst_n = 1'b1;
    #1;
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a got %0b want 1", rdy_a); end
    checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b got %0b want 1", rdy_b); end
  endtask

  task automatic test_frame();
    logic [7:0] exp_d [17];
    exp_d = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h11, 8'h11, 8'h22, 8'h22,
              8'h33, 8'h33, 8'h44, 8'h44, 8'h33, 8'h33, 8'h44, 8'h44, 8'h55};
    do_reset();
    src_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    feed_a(17);
    checks++; if (got_a.size() != 17) begin errors++; $display("FAIL frame_count got %0d want 17", got_a.size()); end
    for (int i = 0; i < 17 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_d[i]) begin errors++; $display("FAIL frame_data[%0d] got %h want %h", i, got_a[i], exp_d[i]); end
      if ((i >= 4 && i <= 7) || (i >= 12 && i <= 15)) begin
        checks++;
        if (rdy_q[i] !== 1'b0) begin errors++; $display("FAIL frame_ready_replay[%0d] got %0b want 0", i, rdy_q[i]); end
      end
    end
    checks++; if (first_out != first_acc) begin errors++; $display("FAIL frame_latency got out@%0d want out@%0d", first_out, first_acc); end
    checks++; if (src_a.size() != 0) begin errors++; $display("FAIL frame_wrap_accept got %0d pending want 0", src_a.size()); end
  endtask

  task automatic test_stall();
    logic       sv [11];
    logic [7:0] sd [11];
    logic       ev [11];
    logic [7:0] ed [11];
    logic       acc;
    sv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    sd = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    ev = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ed = '{8'h11, 8'h11, 8'h00, 8'h00, 8'h22, 8'h22, 8'h11, 8'h11, 8'h22, 8'h22, 8'h00};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step_a(1'b1, sv[i], sv[i] ? sd[i] : 8'($urandom), acc);
      if (sv[i]) begin
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL stall_accept[%0d] got %0b want 1", i, acc); end
      end
      checks++; if (ov_a !== ev[i]) begin errors++; $display("FAIL stall_valid[%0d] got %0b want %0b", i, ov_a, ev[i]); end
      if (ev[i]) begin
        checks++; if (od_a !== ed[i]) begin errors++; $display("FAIL stall_data[%0d] got %h want %h", i, od_a, ed[i]); end
      end
    end
  endtask

  task automatic test_clk_en();
    logic       acc;
    logic [7:0] tail [3];
    tail = '{8'h11, 8'h22, 8'h22};
    do_reset();
    src_a = '{8'h11, 8'h22};
    feed_a(5);
    checks++; if (got_a.size() != 5 || got_a[4] !== 8'h11) begin errors++; $display("FAIL clken_setup got %0d outputs want 5 ending 11", got_a.size()); end
    for (int i = 0; i < 2; i++) begin
      step_a(1'b0, 1'b1, 8'h99, acc);
      checks++; if (ov_a !== 1'b1 || od_a !== 8'h11) begin errors++; $display("FAIL clken_freeze[%0d] got %0b/%h want 1/11", i, ov_a, od_a); end
    end
    for (int i = 0; i < 3; i++) begin
      step_a(1'b1, 1'b0, 8'h00, acc);
      checks++; if (ov_a !== 1'b1 || od_a !== tail[i]) begin errors++; $display("FAIL clken_resume[%0d] got %0b/%h want 1/%h", i, ov_a, od_a, tail[i]); end
    end
    step_a(1'b1, 1'b0, 8'h00, acc);
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL clken_row_end got %0b want 0", ov_a); end
    for (int i = 0; i < 2; i++) begin
      step_a(1'b0, 1'b1, 8'h33, acc);
      checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL clken_no_xfer[%0d] got %0b want 0", i, ov_a); end
    end
    step_a(1'b1, 1'b1, 8'h33, acc);
    checks++; if (ov_a !== 1'b1 || od_a !== 8'h33) begin errors++; $display("FAIL clken_after got %0b/%h want 1/33", ov_a, od_a); end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_d [8];
    exp_d = '{8'h66, 8'h66, 8'h77, 8'h77, 8'h66, 8'h66, 8'h77, 8'h77};
    do_reset();
    src_a = '{8'h11, 8'h22};
    feed_a(5);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (ov_a !== 1'b0 || od_a !== 8'h00) begin errors++; $display("FAIL areset_immediate got %0b/%h want 0/00", ov_a, od_a); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL areset_ready got %0b want 1", rdy_a); end
    src_a = '{8'h66, 8'h77};
    feed_a(8);
    checks++; if (got_a.size() != 8) begin errors++; $display("FAIL areset_count got %0d want 8", got_a.size()); end
    for (int i = 0; i < 8 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_d[i]) begin errors++; $display("FAIL areset_data[%0d] got %h want %h", i, got_a[i], exp_d[i]); end
    end
  endtask

  // Scoreboard: every accepted pixel owes S_A copies now; a completed row owes S_A-1 more passes.
  task automatic test_random_a();
    logic [7:0] exp_q[$];
    logic [7:0] row_pix[$];
    logic [7:0] d, e;
    logic       en, v, acc;
    do_reset();
    d = 8'($urandom);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      en = ($urandom_range(0, 9) < 8);
      v  = (cyc < 1400) && ($urandom_range(0, 9) < 6);
      step_a(en, v, d, acc);
      if (acc) begin
        for (int s = 0; s < S_A; s++) exp_q.push_back(d);
        row_pix.push_back(d);
        if (row_pix.size() == IS_A) begin
          for (int rr = 1; rr < S_A; rr++)
            foreach (row_pix[c])
              for (int s = 0; s < S_A; s++) exp_q.push_back(row_pix[c]);
          row_pix.delete();
        end
        checks++; if (ov_a !== 1'b1 || od_a !== d) begin errors++; $display("FAIL rand_a_latency cyc %0d got %0b/%h want 1/%h", cyc, ov_a, od_a, d); end
        d = 8'($urandom);
      end
      if (en && ov_a) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_a_extra cyc %0d got %h want no output", cyc, od_a);
        end else begin
          e = exp_q.pop_front();
          if (od_a !== e) begin errors++; $display("FAIL rand_a_data cyc %0d got %h want %h", cyc, od_a, e); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_a_missing got %0d left want 0", exp_q.size()); end
  endtask

  // SCALE=1: output is the accepted input one cycle later, and the block is always ready.
  task automatic test_random_b();
    logic [15:0] d;
    logic        en, v, acc;
    int          n_acc, n_out;
    do_reset();
    n_acc = 0; n_out = 0;
    d = 16'($urandom);
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL rand_b_ready cyc %0d got %0b want 1", cyc, rdy_b); end
      en = ($urandom_range(0, 9) < 8);
      v  = ($urandom_range(0, 9) < 6);
      step_b(en, v, d, acc);
      if (acc) begin
        n_acc++;
        checks++; if (ov_b !== 1'b1 || od_b !== d) begin errors++; $display("FAIL rand_b_data cyc %0d got %0b/%h want 1/%h", cyc, ov_b, od_b, d); end
        d = 16'($urandom);
      end else if (en) begin
        checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL rand_b_idle cyc %0d got %0b want 0", cyc, ov_b); end
      end
      if (en && ov_b) n_out++;
    end
    checks++; if (n_out != n_acc) begin errors++; $display("FAIL rand_b_count got %0d want %0d", n_out, n_acc); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_clk_en();
    test_async_reset();
    test_random_a();
    test_random_b();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
